controle_envase: RTL
====================

CONTROLE_ENVASE -- requirements
Module: controle_envase

Interface
REQ-001 Parameter TIMEOUT_ENCHIMENTO, default 15: maximum fill cycles before fault, range 2..255.
REQ-002 Parameter ROLHAS_INICIAL, default 20: cork stock loaded at reset and on refill, range 1..31.
REQ-003 CLOCK  in  1  single system clock, rising edge; one clock; reset is synchronous and active-high.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 START  in  1  level, request line run.
REQ-006 STOP  in  1  level, request line halt.
REQ-007 SENSOR_GARRAFA  in  1  bottle positioned under filler.
REQ-008 SENSOR_NIVEL  in  1  fill level reached.
REQ-009 VEDACAO_OK  in  1  corker done acknowledge.
REQ-010 DUZIA_COMPLETA  in  1  combinational pulse from bottle counter, valid while CONTA=1.
REQ-011 CAIXA_TROCADA  in  1  operator/box-handler acknowledge.
REQ-012 REPOR_ROLHAS  in  1  cork refill strobe.
REQ-013 MOTOR, VALVULA, VEDAR, CONTA, TROCA_CAIXA  out  1 each  conveyor, fill valve, corker command, counter ENABLE, box-swap request.
REQ-014 ALARME_ROLHA, ERRO_ENCHIMENTO  out  1 each  cork stock empty, fill timeout fault.
REQ-015 DUZIAS  out  7  completed dozens, 0..99; ESTADO  out  3  current state code.

Function
REQ-016 FSM states: PARADO, ESTEIRA, ENCHENDO, VEDANDO, CONTANDO, TROCA, ERRO; outputs are Moore decodes of registered state (MOTOR only in ESTEIRA, VALVULA only in ENCHENDO, VEDAR only in VEDANDO, CONTA only in CONTANDO, TROCA_CAIXA only in TROCA, ERRO_ENCHIMENTO only in ERRO).
REQ-017 PARADO -> ESTEIRA when START=1, STOP=0, cork stock > 0; otherwise stay; START with stock 0 ignored.
REQ-018 ESTEIRA: STOP=1 -> PARADO next cycle; else SENSOR_GARRAFA=1 -> ENCHENDO; STOP has priority over SENSOR_GARRAFA.
REQ-019 ENCHENDO: fill timer clears on entry, increments each cycle; SENSOR_NIVEL=1 -> VEDANDO; timer reaching TIMEOUT_ENCHIMENTO-1 with SENSOR_NIVEL=0 -> ERRO; SENSOR_NIVEL wins on the same cycle.
REQ-020 VEDANDO: hold VEDAR until VEDACAO_OK=1 -> CONTANDO; cork stock decrements by 1 on that transition.
REQ-021 CONTANDO lasts exactly one cycle (CONTA single-cycle pulse); DUZIA_COMPLETA sampled in that cycle.
REQ-022 From CONTANDO, in priority: DUZIA_COMPLETA=1 -> TROCA; stock=0 -> PARADO; stop pending -> PARADO; else ESTEIRA.
REQ-023 DUZIAS increments on CONTANDO with DUZIA_COMPLETA=1; 99 wraps to 0.
REQ-024 TROCA: hold TROCA_CAIXA until CAIXA_TROCADA=1, then PARADO if stock=0 or stop pending, else ESTEIRA.
REQ-025 STOP asserted in ENCHENDO, VEDANDO, CONTANDO or TROCA sets a stop-pending flag; current bottle completes; flag clears on entry to PARADO.
REQ-026 ERRO: VALVULA and MOTOR off; exit to PARADO only on START=1 with STOP=0; fault not self-clearing.
REQ-027 REPOR_ROLHAS=1 in any state loads stock to ROLHAS_INICIAL next cycle; refill wins over a simultaneous decrement.
REQ-028 ALARME_ROLHA = (stock == 0), decoded from the stock register.
REQ-029 Stock never decrements below 0.
REQ-030 ESTADO codes: PARADO=0, ESTEIRA=1, ENCHENDO=2, VEDANDO=3, CONTANDO=4, TROCA=5, ERRO=6.

Reset
REQ-031 RESET=1 at a rising edge forces PARADO, stock=ROLHAS_INICIAL, DUZIAS=0, fill timer=0, stop-pending=0; all 1-bit outputs 0 the following cycle.
REQ-032 RESET mid-operation (any state) aborts the bottle without stock decrement or count pulse; RESET dominates every other input.

Structure
REQ-033 Shared package pkg_envase holds state encodings, ROLHAS_MAX=31 and DUZIAS_MAX=99.
REQ-034 Fill timeout counter is one sub-module, temporizador_enchimento (clear, enable, expired flag).
REQ-035 CONTA/DUZIA_COMPLETA connect directly to contadorgarrafas ENABLE/DUZIA_COMPLETA on the same CLOCK/RESET.

Verification
REQ-036 Reset, START, 12 full bottles (sensor, level after 3 cycles, ack after 2) -> 12 CONTA pulses, TROCA on 12th, CAIXA_TROCADA -> ESTEIRA, DUZIAS=1, stock=8.
REQ-037 ENCHENDO with SENSOR_NIVEL held 0 -> ERRO exactly 15 cycles after entry, ERRO_ENCHIMENTO=1; START -> PARADO.
REQ-038 STOP during VEDANDO -> bottle completes, one CONTA pulse, then PARADO; STOP in ESTEIRA -> PARADO next cycle.
REQ-039 ROLHAS_INICIAL=2 -> after 2nd bottle PARADO, ALARME_ROLHA=1, START ignored; REPOR_ROLHAS -> stock=2, alarm clears, START runs.
REQ-040 REPOR_ROLHAS on same cycle as VEDACAO_OK -> stock=ROLHAS_INICIAL; RESET during TROCA -> PARADO, DUZIAS=0.

Source files
------------

// File: rtl/controle_envase_pkg.sv
// pkg_envase -- shared definitions for the bottling-line controller.
//   estado_t      : FSM state encoding (also exported on ESTADO)
//   ROLHAS_MAX    : largest cork stock the stock register must hold
//   DUZIAS_MAX    : last value of the dozens counter before it wraps to 0
//   proxima_duzia : dozens counter successor with the 99 -> 0 wrap
package pkg_envase;

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    ESTEIRA  = 3'd1,
    ENCHENDO = 3'd2,
    VEDANDO  = 3'd3,
    CONTANDO = 3'd4,
    TROCA    = 3'd5,
    ERRO     = 3'd6
  } estado_t;

  localparam int ROLHAS_MAX = 31;
  localparam int DUZIAS_MAX = 99;
  localparam int ROLHAS_W   = $clog2(ROLHAS_MAX + 1);
  localparam int DUZIAS_W   = 7;
  localparam int TEMPO_W    = 8;

  function automatic logic [DUZIAS_W-1:0] proxima_duzia(input logic [DUZIAS_W-1:0] d);
    if (d >= DUZIAS_W'(DUZIAS_MAX)) begin
      return '0;
    end
    return d + 1'b1;
  endfunction

endpackage

// File: rtl/controle_envase_temporizador.sv
// temporizador_enchimento -- fill timeout counter.
//   i_clk      : system clock
//   i_srst     : synchronous active-high reset
//   i_clr      : holds the count at zero (asserted whenever not filling)
//   i_en       : counts one per cycle while filling
//   o_expirado : count has reached TIMEOUT-1
module temporizador_enchimento
  import pkg_envase::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expirado
);

  localparam logic [TEMPO_W-1:0] LIMITE = TEMPO_W'(TIMEOUT - 1);

  logic [TEMPO_W-1:0] r_contagem;

  // Saturates instead of wrapping, so a stuck enable can never make the
  // expired flag pulse a second time.
  always_ff @(posedge i_clk) begin
    if (i_srst || i_clr) begin
      r_contagem <= '0;
    end else if (i_en && (r_contagem != '1)) begin
      r_contagem <= r_contagem + 1'b1;
    end
  end

  assign o_expirado = (r_contagem == LIMITE);

endmodule

// File: rtl/controle_envase.sv
// controle_envase -- bottling line controller (fill, cork, count, box swap).
// Inputs : CLOCK, RESET (sync, active-high), START/STOP request levels,
//          SENSOR_GARRAFA, SENSOR_NIVEL, VEDACAO_OK, DUZIA_COMPLETA (from the
//          bottle counter, valid while CONTA=1), CAIXA_TROCADA, REPOR_ROLHAS.
// Outputs: MOTOR, VALVULA, VEDAR, CONTA, TROCA_CAIXA, ERRO_ENCHIMENTO (Moore
//          decodes of the state register), ALARME_ROLHA (stock empty),
//          DUZIAS (completed dozens 0..99), ESTADO (state code).
module controle_envase
  import pkg_envase::*;
#(
  parameter int TIMEOUT_ENCHIMENTO = 15,
  parameter int ROLHAS_INICIAL     = 20
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                START,
  input  logic                STOP,
  input  logic                SENSOR_GARRAFA,
  input  logic                SENSOR_NIVEL,
  input  logic                VEDACAO_OK,
  input  logic                DUZIA_COMPLETA,
  input  logic                CAIXA_TROCADA,
  input  logic                REPOR_ROLHAS,
  output logic                MOTOR,
  output logic                VALVULA,
  output logic                VEDAR,
  output logic                CONTA,
  output logic                TROCA_CAIXA,
  output logic                ALARME_ROLHA,
  output logic                ERRO_ENCHIMENTO,
  output logic [DUZIAS_W-1:0] DUZIAS,
  output logic [2:0]          ESTADO
);

  localparam logic [ROLHAS_W-1:0] ROLHAS_INI = ROLHAS_W'(ROLHAS_INICIAL);

  estado_t             r_estado;
  estado_t             w_proximo;
  logic [ROLHAS_W-1:0] r_estoque;
  logic [DUZIAS_W-1:0] r_duzias;
  logic                r_stop_pend;
  logic                w_stop_efetivo;
  logic                w_sem_rolha;
  logic                w_consome;
  logic                w_expirado;

  temporizador_enchimento #(
    .TIMEOUT (TIMEOUT_ENCHIMENTO)
  ) u_temporizador (
    .i_clk      (CLOCK),
    .i_srst     (RESET),
    .i_clr      (r_estado != ENCHENDO),
    .i_en       (r_estado == ENCHENDO),
    .o_expirado (w_expirado)
  );

  assign w_sem_rolha = (r_estoque == '0);
  assign w_consome   = (r_estado == VEDANDO) && VEDACAO_OK && !w_sem_rolha;

  // A STOP seen while a bottle is in flight is honoured at the next exit
  // point; the live STOP is folded in so a request raised in CONTANDO or
  // TROCA takes effect on that very exit.
  assign w_stop_efetivo = r_stop_pend ||
                          (STOP && ((r_estado == ENCHENDO) || (r_estado == VEDANDO) ||
                                    (r_estado == CONTANDO) || (r_estado == TROCA)));

  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      PARADO:   if (START && !STOP && !w_sem_rolha) w_proximo = ESTEIRA;
      ESTEIRA: begin
        if (STOP)                w_proximo = PARADO;
        else if (SENSOR_GARRAFA) w_proximo = ENCHENDO;
      end
      ENCHENDO: begin
        if (SENSOR_NIVEL)        w_proximo = VEDANDO;
        else if (w_expirado)     w_proximo = ERRO;
      end
      VEDANDO:  if (VEDACAO_OK) w_proximo = CONTANDO;
      CONTANDO: begin
        if (DUZIA_COMPLETA)                   w_proximo = TROCA;
        else if (w_sem_rolha || w_stop_efetivo) w_proximo = PARADO;
        else                                  w_proximo = ESTEIRA;
      end
      TROCA: begin
        if (CAIXA_TROCADA) begin
          w_proximo = (w_sem_rolha || w_stop_efetivo) ? PARADO : ESTEIRA;
        end
      end
      ERRO:     if (START && !STOP) w_proximo = PARADO;
      default:  w_proximo = PARADO;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_estado    <= PARADO;
      r_estoque   <= ROLHAS_INI;
      r_duzias    <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_estado    <= w_proximo;
      r_stop_pend <= (w_proximo == PARADO) ? 1'b0 : w_stop_efetivo;
      // Refill takes precedence over the cork consumed on the same edge.
      if (REPOR_ROLHAS) begin
        r_estoque <= ROLHAS_INI;
      end else if (w_consome) begin
        r_estoque <= r_estoque - 1'b1;
      end
      if ((r_estado == CONTANDO) && DUZIA_COMPLETA) begin
        r_duzias <= proxima_duzia(r_duzias);
      end
    end
  end

  assign MOTOR           = (r_estado == ESTEIRA);
  assign VALVULA         = (r_estado == ENCHENDO);
  assign VEDAR           = (r_estado == VEDANDO);
  assign CONTA           = (r_estado == CONTANDO);
  assign TROCA_CAIXA     = (r_estado == TROCA);
  assign ERRO_ENCHIMENTO = (r_estado == ERRO);
  assign ALARME_ROLHA    = w_sem_rolha;
  assign DUZIAS          = r_duzias;
  assign ESTADO          = r_estado;

endmodule
